// File: rtl/div_seq.sv
// Sequential restoring divider for MIPS div/divu: one quotient bit per cycle, sign fix-up after.
// Optional macro DIV_EARLY_OUT_EN: finish at accept when |dividend| < |divisor|.
module div_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] q_work;
    logic [WIDTH-1:0] dvs_work;
    logic [WIDTH-1:0] rem_work;
    logic             q_neg;
    logic             r_neg;
    logic             dbz;

    function automatic logic [WIDTH-1:0] neg_cond(input logic [WIDTH-1:0] v, input logic neg);
        logic signed [WIDTH-1:0] sv;
        sv = v;
        return neg ? -sv : sv;
    endfunction

    logic             accept;
    logic             dvd_neg_in;
    logic             dvs_neg_in;
    logic [WIDTH-1:0] dvd_abs;
    logic [WIDTH-1:0] dvs_abs;
    logic             dvs_zero;
    logic             early;

    assign accept     = start && (state == IDLE || state == DONE);
    assign dvd_neg_in = is_signed & dividend[WIDTH-1];
    assign dvs_neg_in = is_signed & divisor[WIDTH-1];
    assign dvd_abs    = neg_cond(dividend, dvd_neg_in);
    assign dvs_abs    = neg_cond(divisor, dvs_neg_in);
    assign dvs_zero   = (divisor == '0);

`ifdef DIV_EARLY_OUT_EN
    assign early = !dvs_zero && (dvd_abs < dvs_abs);
`else
    assign early = 1'b0;
`endif

    // Restoring step: a borrow out of the extra top bit means the trial subtract failed.
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic             step_ge;
    logic [WIDTH-1:0] rem_step;

    assign shifted  = {rem_work, q_work[WIDTH-1]};
    assign trial    = shifted - {1'b0, dvs_work};
    assign step_ge  = !trial[WIDTH];
    assign rem_step = step_ge ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: begin
                if (accept) begin
                    state_nxt = (dvs_zero || early) ? DONE : CALC;
                end else begin
                    state_nxt = IDLE;
                end
            end
            CALC: begin
                if (cnt == CNT_LAST) begin
                    state_nxt = FIX;
                end
            end
            FIX: begin
                state_nxt = DONE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign busy        = (state == CALC) || (state == FIX);
    assign done        = (state == DONE);
    assign div_by_zero = done && dbz;

    // Control and architectural results: cleared by reset, updated only at accept or in FIX.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            dbz       <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                cnt <= '0;
                dbz <= dvs_zero;
                if (dvs_zero) begin
                    quotient  <= '1;
                    remainder <= dividend;
                end else if (early) begin
                    quotient  <= '0;
                    remainder <= dividend;
                end
            end else if (state == CALC) begin
                cnt <= cnt + CNT_W'(1);
            end else if (state == FIX) begin
                quotient  <= neg_cond(q_work, q_neg);
                remainder <= neg_cond(rem_work, r_neg);
            end
        end
    end

    // Working datapath: quotient bits shift into q_work as dividend bits shift out.
    always_ff @(posedge clk) begin
        if (accept) begin
            q_work   <= dvd_abs;
            dvs_work <= dvs_abs;
            rem_work <= '0;
            q_neg    <= dvd_neg_in ^ dvs_neg_in;
            r_neg    <= dvd_neg_in;
        end else if (state == CALC) begin
            q_work   <= {q_work[WIDTH-2:0], step_ge};
            rem_work <= rem_step;
        end
    end

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: vector table, hand-written corner sequences, randomized ops.
module tb_div_seq;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         is_signed = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         busy;
    logic         done;
    logic         div_by_zero;

    int n_chk = 0;
    int n_pass = 0;

    div_seq #(.WIDTH(W)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .is_signed(is_signed),
        .dividend(dividend),
        .divisor(divisor),
        .quotient(quotient),
        .remainder(remainder),
        .busy(busy),
        .done(done),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         s;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
    } vec_t;

    vec_t tbl[14];

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Reference: plain integer division, truncating toward zero, with latency from the timing rules.
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                                  output logic [W-1:0] q, output logic [W-1:0] r,
                                  output logic dz, output int lat, output int bsy);
        longint sa, sb, ma, mb;
        logic   early;
        sa = s ? longint'($signed(a)) : longint'(a);
        sb = s ? longint'($signed(b)) : longint'(b);
        if (b == 0) begin
            q = '1;
            r = a;
            dz = 1'b1;
            lat = 1;
            bsy = 0;
        end else begin
            q  = W'(sa / sb);
            r  = W'(sa % sb);
            dz = 1'b0;
            ma = (sa < 0) ? -sa : sa;
            mb = (sb < 0) ? -sb : sb;
`ifdef DIV_EARLY_OUT_EN
            early = (ma < mb);
`else
            early = 1'b0;
`endif
            lat = early ? 1 : W + 2;
            bsy = early ? 0 : W + 1;
        end
    endfunction

    // Issue one operation from idle and observe it until done (bounded).
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                          output logic [W-1:0] q, output logic [W-1:0] r, output logic dz,
                          output int lat, output int busy_n, output logic clean);
        logic [W-1:0] pq, pr;
        @(negedge clk);
        start = 1'b1;
        dividend = a;
        divisor = b;
        is_signed = s;
        pq = quotient;
        pr = remainder;
        @(negedge clk);
        start = 1'b0;
        dividend = $urandom;
        divisor = $urandom;
        lat = 1;
        busy_n = 0;
        clean = 1'b1;
        while (!done && lat < 200) begin
            if (busy) busy_n++;
            if (quotient !== pq || remainder !== pr || div_by_zero !== 1'b0) clean = 1'b0;
            @(negedge clk);
            lat++;
        end
        q = quotient;
        r = remainder;
        dz = div_by_zero;
    endtask

    task automatic check_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic s, input logic [W-1:0] eq, input logic [W-1:0] er,
                            input logic edz);
        logic [W-1:0] q, r, mq, mr;
        logic         dz, mdz, clean;
        int           lat, bn, mlat, mbsy;
        model(a, b, s, mq, mr, mdz, mlat, mbsy);
        run_op(a, b, s, q, r, dz, lat, bn, clean);
        chk({tag, "_quot"}, q, eq);
        chk({tag, "_rem"}, r, er);
        chk({tag, "_dbz"}, W'(dz), W'(edz));
        chk({tag, "_latency"}, W'(lat), W'(mlat));
        chk({tag, "_busy_cycles"}, W'(bn), W'(mbsy));
        chk({tag, "_hold_clean"}, W'(clean), W'(1));
        @(negedge clk);
        chk({tag, "_done_pulse_end"}, W'({done, div_by_zero, busy}), W'(0));
    endtask

    initial begin
        logic [W-1:0] q, r, a, b, mq, mr;
        logic         dz, s, mdz, clean;
        int           lat, bn, mlat, mbsy;
        bit           seen;

        tbl[0]  = '{32'd100,        32'd7,          1'b0, 32'd14,         32'd2,          1'b0};
        tbl[1]  = '{32'hFFFFFFF9,   32'd2,          1'b1, 32'hFFFFFFFD,   32'hFFFFFFFF,   1'b0};
        tbl[2]  = '{32'h80000000,   32'hFFFFFFFF,   1'b1, 32'h80000000,   32'd0,          1'b0};
        tbl[3]  = '{32'h00001234,   32'd0,          1'b0, 32'hFFFFFFFF,   32'h00001234,   1'b1};
        tbl[4]  = '{32'h80000000,   32'hFFFFFFFF,   1'b0, 32'd0,          32'h80000000,   1'b0};
        tbl[5]  = '{32'hFFFFFFFF,   32'd1,          1'b0, 32'hFFFFFFFF,   32'd0,          1'b0};
        tbl[6]  = '{32'd7,          32'hFFFFFFFE,   1'b1, 32'hFFFFFFFD,   32'd1,          1'b0};
        tbl[7]  = '{32'hFFFFFFF9,   32'hFFFFFFFE,   1'b1, 32'd3,          32'hFFFFFFFF,   1'b0};
        tbl[8]  = '{32'hFFFFFFF9,   32'd2,          1'b0, 32'h7FFFFFFC,   32'd1,          1'b0};
        tbl[9]  = '{32'd5,          32'd5,          1'b0, 32'd1,          32'd0,          1'b0};
        tbl[10] = '{32'd3,          32'd9,          1'b1, 32'd0,          32'd3,          1'b0};
        tbl[11] = '{32'd0,          32'd0,          1'b1, 32'hFFFFFFFF,   32'd0,          1'b1};
        tbl[12] = '{32'hFFFFFFF8,   32'd0,          1'b1, 32'hFFFFFFFF,   32'hFFFFFFF8,   1'b1};
        tbl[13] = '{32'h80000000,   32'd1,          1'b1, 32'h80000000,   32'd0,          1'b0};

        // Reset state
        #12;
        chk("reset_outputs", {quotient[15:0], remainder[15:0]}, 32'd0);
        chk("reset_flags", W'({busy, done, div_by_zero}), W'(0));
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            check_op($sformatf("tbl%0d", i), tbl[i].a, tbl[i].b, tbl[i].s,
                     tbl[i].q, tbl[i].r, tbl[i].dz);
        end

        // Start held through CALC with junk operands, then back-to-back accept in DONE
        @(negedge clk);
        start = 1'b1;
        is_signed = 1'b0;
        dividend = 32'd100;
        divisor = 32'd7;
        @(negedge clk);
        dividend = 32'd0;
        divisor = 32'd0;
        lat = 1;
        while (!done && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        chk("b2b_first_latency", W'(lat), W'(W + 2));
        chk("b2b_first_quot", quotient, 32'd14);
        chk("b2b_first_rem", remainder, 32'd2);
        chk("b2b_first_dbz", W'(div_by_zero), W'(0));
        dividend = 32'd1000;
        divisor = 32'd3;
        @(negedge clk);
        chk("b2b_no_gap_busy", W'({busy, done}), W'(2'b10));
        start = 1'b0;
        lat = 1;
        while (!done && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        chk("b2b_second_latency", W'(lat), W'(W + 2));
        chk("b2b_second_quot", quotient, 32'd333);
        chk("b2b_second_rem", remainder, 32'd1);
        @(negedge clk);

        // Reset in the middle of CALC aborts with no done pulse
        @(negedge clk);
        start = 1'b1;
        dividend = 32'h0000FFFF;
        divisor = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        chk("abort_busy_before", W'(busy), W'(1));
        rst_n = 1'b0;
        #1;
        chk("abort_quot", quotient, 32'd0);
        chk("abort_rem", remainder, 32'd0);
        chk("abort_flags", W'({busy, done, div_by_zero}), W'(0));
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done || busy || div_by_zero) seen = 1'b1;
        end
        chk("abort_no_done", W'(seen), W'(0));
        check_op("after_reset_5_5", 32'd5, 32'd5, 1'b0, 32'd1, 32'd0, 1'b0);
        check_op("after_reset_3_9", 32'd3, 32'd9, 1'b0, 32'd0, 32'd3, 1'b0);

        // Randomized operations against the reference model
        for (int k = 0; k < 40; k++) begin
            a = $urandom;
            case ($urandom_range(0, 4))
                0: b = 32'd0;
                1: b = $urandom_range(1, 15);
                2: b = $urandom;
                3: b = a >> $urandom_range(0, 31);
                default: b = 32'hFFFFFFFF;
            endcase
            if (k % 10 == 3) a = 32'h80000000;
            s = $urandom_range(0, 1);
            model(a, b, s, mq, mr, mdz, mlat, mbsy);
            check_op($sformatf("rnd%0d", k), a, b, s, mq, mr, mdz);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
